// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter that shares one W-bit bitwise
// logic unit among N_REQ requesters and returns tagged results.
// Optional feature macro: LOGIC_ARB_OPSEL_EN adds the per-requester req_op
// port (00 AND, 01 OR, 10 XOR, 11 NAND). Without it the unit is a fixed AND.
//
// Handshake: res_valid rises in HOLD and stays high, with res_data/res_id
// stable, until a cycle where res_ready is also high; that edge completes the
// transfer. ack is a one-cycle pulse in EXEC that tells the requester its
// operands were captured and it may change or drop them.
module logic_unit_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*W-1:0]         req_a,
   input  logic [N_REQ*W-1:0]         req_b,
`ifdef LOGIC_ARB_OPSEL_EN
   input  logic [N_REQ*2-1:0]         req_op,
`endif
   output logic [N_REQ-1:0]           ack,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [W-1:0]               res_data,
   output logic [$clog2(N_REQ)-1:0]   res_id,
   output logic [7:0]                 op_count,
   output logic                       busy,
   output logic [1:0]                 dbg_state
);

   localparam int IW = $clog2(N_REQ);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [IW-1:0]    id_q, id_d;
   logic [W-1:0]     res_data_q, res_data_d;
   logic             res_valid_q, res_valid_d;
   logic [7:0]       op_count_q, op_count_d;

   logic             gnt_found;
   logic [IW-1:0]    gnt_idx;
   logic [IW-1:0]    scan_idx;
   logic [W-1:0]     alu_r;

`ifdef LOGIC_ARB_OPSEL_EN
   logic [1:0]       op_q, op_d;
`endif

   // Round-robin search: first set req bit starting at ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = ptr_q + IW'(k);
         if (!gnt_found && req[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx;
         end
      end
   end

   // Shared bitwise unit operating on the captured operands.
   always_comb begin
`ifdef LOGIC_ARB_OPSEL_EN
      case (op_q)
         2'b00:   alu_r = a_q & b_q;
         2'b01:   alu_r = a_q | b_q;
         2'b10:   alu_r = a_q ^ b_q;
         default: alu_r = ~(a_q & b_q);
      endcase
`else
      alu_r = a_q & b_q;
`endif
   end

   // Sequencer next-state: capture in IDLE, compute in EXEC, present in HOLD.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      ack_d       = '0;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      op_count_d  = op_count_q;
`ifdef LOGIC_ARB_OPSEL_EN
      op_d        = op_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_found) begin
               state_d = EXEC;
               ack_d   = N_REQ'(1) << gnt_idx;
               a_d     = req_a[gnt_idx*W +: W];
               b_d     = req_b[gnt_idx*W +: W];
               id_d    = gnt_idx;
               ptr_d   = gnt_idx + IW'(1);
`ifdef LOGIC_ARB_OPSEL_EN
               op_d    = req_op[gnt_idx*2 +: 2];
`endif
            end
         end
         EXEC: begin
            state_d     = HOLD;
            res_data_d  = alu_r;
            res_valid_d = 1'b1;
         end
         HOLD: begin
            if (res_valid_q && res_ready) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
               op_count_d  = op_count_q + 8'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset discards any in-flight transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         ack_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         op_count_q  <= 8'd0;
`ifdef LOGIC_ARB_OPSEL_EN
         op_q        <= 2'b00;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         ack_q       <= ack_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         op_count_q  <= op_count_d;
`ifdef LOGIC_ARB_OPSEL_EN
         op_q        <= op_d;
`endif
      end
   end

   assign ack       = ack_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = id_q;
   assign op_count  = op_count_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed, table-driven bench for logic_unit_arbiter (N_REQ=4, W=8).
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_a;
   logic [31:0] req_b;
`ifdef LOGIC_ARB_OPSEL_EN
   logic [7:0]  req_op;
`endif
   logic [3:0]  ack;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic [1:0]  res_id;
   logic [7:0]  op_count;
   logic        busy;
   logic [1:0]  dbg_state;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_cnt = 8'd0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] a;
      logic [31:0] b;
      int          id;
      logic [7:0]  data;
   } vec_t;
   vec_t vecs[9];

   logic_unit_arbiter #(.N_REQ(4), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
`ifdef LOGIC_ARB_OPSEL_EN
      .req_op    (req_op),
`endif
      .ack       (ack),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .op_count  (op_count),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One full transfer starting from IDLE with res_ready high.
   task automatic do_xfer(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                          input int eid, input logic [7:0] ed, input string nm);
      req = r; req_a = a; req_b = b; res_ready = 1'b1;
      step();
      chk({nm, " ack"}, ack, 32'(4'b0001 << eid));
      chk({nm, " busy_exec"}, busy, 1);
      chk({nm, " state_exec"}, dbg_state, 1);
      chk({nm, " valid_exec"}, res_valid, 0);
      req = 4'b0000;
      step();
      chk({nm, " valid_hold"}, res_valid, 1);
      chk({nm, " data"}, res_data, ed);
      chk({nm, " id"}, res_id, eid);
      chk({nm, " ack_hold"}, ack, 0);
      step();
      exp_cnt = exp_cnt + 8'd1;
      chk({nm, " op_count"}, op_count, exp_cnt);
      chk({nm, " valid_done"}, res_valid, 0);
      chk({nm, " busy_done"}, busy, 0);
   endtask

   initial begin
      int g;
      // ptr evolves across the table; expected ids track it by hand.
      vecs[0] = '{4'b0001, 32'h112233F0, 32'hFFFFFF3C, 0, 8'h30};
      vecs[1] = '{4'b1111, 32'h11223344, 32'hF00FFFFF, 1, 8'h33};
      vecs[2] = '{4'b1001, 32'h81422418, 32'h0FF03CC3, 3, 8'h01};
      vecs[3] = '{4'b0110, 32'hFFAA5500, 32'h000FF0FF, 1, 8'h50};
      vecs[4] = '{4'b0010, 32'h0000C300, 32'h00003F00, 1, 8'h03};
      vecs[5] = '{4'b0100, 32'h009A0000, 32'h00F00000, 2, 8'h90};
      vecs[6] = '{4'b0101, 32'h00EE0077, 32'h00FF000F, 0, 8'h07};
      vecs[7] = '{4'b0101, 32'h00EE0077, 32'h00FF000F, 2, 8'hEE};
      vecs[8] = '{4'b1000, 32'hAA000000, 32'h0F000000, 3, 8'h0A};

      // Reset
      rst = 1'b1; req = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
`ifdef LOGIC_ARB_OPSEL_EN
      req_op = 8'h00;
`endif
      repeat (2) step();
      chk("rst ack", ack, 0);
      chk("rst res_valid", res_valid, 0);
      chk("rst res_data", res_data, 0);
      chk("rst res_id", res_id, 0);
      chk("rst op_count", op_count, 0);
      chk("rst busy", busy, 0);
      chk("rst state", dbg_state, 0);
      rst = 1'b0;
      step();

      // Table of single transfers
      foreach (vecs[i]) begin
         do_xfer(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].data,
                 $sformatf("vec%0d", i));
      end

      // Round-robin rotation with all requesters active (ptr is 0 here)
      req = 4'b1111; req_a = 32'h44332211; req_b = 32'hFFFFFFFF; res_ready = 1'b1;
      g = 0;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (c % 3 == 1) chk($sformatf("rr ack c%0d", c), ack, 32'(4'b0001 << (g % 4)));
         else            chk($sformatf("rr ack c%0d", c), ack, 0);
         if (c % 3 == 2) begin
            chk($sformatf("rr id c%0d", c), res_id, g % 4);
            chk($sformatf("rr data c%0d", c), res_data, 32'(g % 4 + 1) * 32'h11);
            g++;
         end
         if (c % 3 == 0) begin
            exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("rr op_count c%0d", c), op_count, exp_cnt);
         end
      end
      req = 4'b0000;

      // Backpressure in HOLD (ptr is 1 here)
      req = 4'b0010; req_a = 32'h00006B00; req_b = 32'h0000F600; res_ready = 1'b0;
      step();
      chk("bp ack", ack, 4'b0010);
      req = 4'b1111;
      step();
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("bp valid %0d", c), res_valid, 1);
         chk($sformatf("bp data %0d", c), res_data, 8'h62);
         chk($sformatf("bp id %0d", c), res_id, 1);
         chk($sformatf("bp ack %0d", c), ack, 0);
         chk($sformatf("bp op_count %0d", c), op_count, exp_cnt);
         step();
      end
      res_ready = 1'b1;
      req = 4'b0000;
      step();
      exp_cnt = exp_cnt + 8'd1;
      chk("bp release valid", res_valid, 0);
      chk("bp release op_count", op_count, exp_cnt);
      chk("bp release state", dbg_state, 0);

      // Reset during EXEC
      req = 4'b0100; req_a = 32'h00550000; req_b = 32'h00FF0000;
      step();
      chk("mid ack", ack, 4'b0100);
      req = 4'b0000;
      #2 rst = 1'b1;
      #1;
      chk("mid rst ack", ack, 0);
      chk("mid rst valid", res_valid, 0);
      chk("mid rst busy", busy, 0);
      chk("mid rst op_count", op_count, 0);
      chk("mid rst data", res_data, 0);
      chk("mid rst id", res_id, 0);
      step();
      rst = 1'b0;
      exp_cnt = 8'd0;
      step();
      chk("post rst valid", res_valid, 0);
      do_xfer(4'b1000, 32'h5A000000, 32'hFF000000, 3, 8'h5A, "post_rst");

      // Op select (ptr is 0 here)
`ifdef LOGIC_ARB_OPSEL_EN
      req_op = 8'b00000001;
      do_xfer(4'b0001, 32'h000000AA, 32'h0000000F, 0, 8'hAF, "op_or");
      req_op = 8'b00000010;
      do_xfer(4'b0001, 32'h000000AA, 32'h0000000F, 0, 8'hA5, "op_xor");
      req_op = 8'b00000011;
      do_xfer(4'b0001, 32'h000000AA, 32'h0000000F, 0, 8'hF5, "op_nand");
      req_op = 8'b00000000;
      do_xfer(4'b0001, 32'h000000AA, 32'h0000000F, 0, 8'h0A, "op_and");
`else
      do_xfer(4'b0001, 32'h000000AA, 32'h0000000F, 0, 8'h0A, "op_fixed_and");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
